// File: rtl/lcd1602_pkg.sv
// Shared definitions for the HD44780 16x2 refresh controller: LCD command bytes,
// sequencer states and byte-transfer phases.
package lcd1602_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_CLR_WAIT,
      ST_ADDR1,
      ST_LINE1,
      ST_ADDR2,
      ST_LINE2
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } phase_t;

   // Init command sequence, in issue order
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd1602_byte_xfer.sv
// Tick-paced single-byte LCD write: SETUP -> PULSE -> HOLD, one tick each.
// A start coinciding with done chains the next byte with no idle gap.
module lcd1602_byte_xfer
   import lcd1602_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] xfer_byte,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic [7:0] LCD_DATA,
   output logic       done
);

   phase_t phase;
   phase_t phase_next;

   always_comb begin
      phase_next = phase;
      done       = 1'b0;
      if (phase == PH_HOLD && tick) begin
         done = 1'b1;
      end
      if (start) begin
         phase_next = PH_SETUP;
      end else if (tick) begin
         case (phase)
            PH_SETUP: phase_next = PH_PULSE;
            PH_PULSE: phase_next = PH_HOLD;
            PH_HOLD:  phase_next = PH_IDLE;
            default:  phase_next = phase;
         endcase
      end
   end

   // RS/DATA latched once at start and held for the whole transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase    <= PH_IDLE;
         LCD_EN   <= 1'b0;
         LCD_RS   <= 1'b0;
         LCD_DATA <= 8'h00;
      end else begin
         phase  <= phase_next;
         LCD_EN <= (phase_next == PH_PULSE);
         if (start) begin
            LCD_RS   <= rs;
            LCD_DATA <= xfer_byte;
         end
      end
   end

endmodule

// File: rtl/lcd1602_refresh_ctrl.sv
// HD44780 16x2 controller: power-up wait, init commands, then endless refresh
// of both lines from a host-written 32-character frame buffer.
module lcd1602_refresh_ctrl
   import lcd1602_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned PWR_TICKS = 20,
   parameter int unsigned CLR_TICKS = 2
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       init_done,
   output logic       frame_done,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_ON
);

   localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WAIT_MAX = (PWR_TICKS > CLR_TICKS) ? PWR_TICKS : CLR_TICKS;
   localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

   logic [CNT_W-1:0]  tick_cnt;
   logic              tick;
   logic [7:0]        char_buf [32];
   state_t            state;
   state_t            state_d;
   logic [WAIT_W-1:0] wcnt;
   logic [WAIT_W-1:0] wcnt_d;
   logic [3:0]        idx;
   logic [3:0]        idx_d;
   logic [3:0]        next_idx;
   logic              start;
   logic              xfer_rs;
   logic [7:0]        xfer_byte;
   logic              xfer_done;
   logic              set_init;
   logic              frame_end;

   assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
   assign next_idx = idx + 4'd1;
   assign LCD_RW   = 1'b0;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            char_buf[i] <= 8'h20;
         end
      end else if (wr_en) begin
         char_buf[wr_addr] <= wr_data;
      end
   end

   // Each transfer state means "that byte is on the bus"; the next byte starts on its done
   always_comb begin
      state_d   = state;
      wcnt_d    = wcnt;
      idx_d     = idx;
      start     = 1'b0;
      xfer_rs   = 1'b0;
      xfer_byte = 8'h00;
      set_init  = 1'b0;
      frame_end = 1'b0;
      case (state)
         ST_PWR_WAIT: begin
            if (tick) begin
               if (wcnt == WAIT_W'(PWR_TICKS - 1)) begin
                  start     = 1'b1;
                  xfer_byte = CMD_FUNC_SET;
                  idx_d     = '0;
                  state_d   = ST_INIT;
               end else begin
                  wcnt_d = wcnt + WAIT_W'(1);
               end
            end
         end
         ST_INIT: begin
            if (xfer_done) begin
               if (idx == 4'd3) begin
                  idx_d   = '0;
                  wcnt_d  = '0;
                  state_d = ST_CLR_WAIT;
               end else begin
                  idx_d     = next_idx;
                  start     = 1'b1;
                  xfer_byte = init_cmd(next_idx[1:0]);
               end
            end
         end
         ST_CLR_WAIT: begin
            if (tick) begin
               if (wcnt == WAIT_W'(CLR_TICKS - 1)) begin
                  set_init  = 1'b1;
                  start     = 1'b1;
                  xfer_byte = CMD_LINE1;
                  state_d   = ST_ADDR1;
               end else begin
                  wcnt_d = wcnt + WAIT_W'(1);
               end
            end
         end
         ST_ADDR1: begin
            if (xfer_done) begin
               start     = 1'b1;
               xfer_rs   = 1'b1;
               xfer_byte = char_buf[{1'b0, idx}];
               state_d   = ST_LINE1;
            end
         end
         ST_LINE1: begin
            if (xfer_done) begin
               idx_d = next_idx;
               start = 1'b1;
               if (idx == 4'd15) begin
                  xfer_byte = CMD_LINE2;
                  state_d   = ST_ADDR2;
               end else begin
                  xfer_rs   = 1'b1;
                  xfer_byte = char_buf[{1'b0, next_idx}];
               end
            end
         end
         ST_ADDR2: begin
            if (xfer_done) begin
               start     = 1'b1;
               xfer_rs   = 1'b1;
               xfer_byte = char_buf[{1'b1, idx}];
               state_d   = ST_LINE2;
            end
         end
         ST_LINE2: begin
            if (xfer_done) begin
               idx_d = next_idx;
               start = 1'b1;
               if (idx == 4'd15) begin
                  frame_end = 1'b1;
                  xfer_byte = CMD_LINE1;
                  state_d   = ST_ADDR1;
               end else begin
                  xfer_rs   = 1'b1;
                  xfer_byte = char_buf[{1'b1, next_idx}];
               end
            end
         end
         default: state_d = ST_PWR_WAIT;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state      <= ST_PWR_WAIT;
         wcnt       <= '0;
         idx        <= '0;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
         LCD_ON     <= 1'b0;
      end else begin
         state      <= state_d;
         wcnt       <= wcnt_d;
         idx        <= idx_d;
         init_done  <= init_done | set_init;
         frame_done <= frame_end;
         LCD_ON     <= 1'b1;
      end
   end

   lcd1602_byte_xfer u_xfer (
      .clk       (sys_clk),
      .rst       (rst),
      .tick      (tick),
      .start     (start),
      .rs        (xfer_rs),
      .xfer_byte (xfer_byte),
      .LCD_EN    (LCD_EN),
      .LCD_RS    (LCD_RS),
      .LCD_DATA  (LCD_DATA),
      .done      (xfer_done)
   );

endmodule

// File: tb/tb_lcd1602_refresh_ctrl.sv
// Bench for lcd1602_refresh_ctrl: a tick-timeline model predicts every bus cycle
// from transfer index arithmetic and a mirror of the host-written frame buffer.
module tb_lcd1602_refresh_ctrl;

   localparam int unsigned D  = 4;
   localparam int unsigned P  = 3;
   localparam int unsigned C  = 2;
   localparam int unsigned F0 = P + 12 + C;   // tick at which the first frame starts
   localparam int unsigned FT = 34 * 3;       // ticks per frame

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b1;
   logic       wr_en   = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       init_done;
   logic       frame_done;
   logic [7:0] LCD_DATA;
   logic       LCD_RS;
   logic       LCD_RW;
   logic       LCD_EN;
   logic       LCD_ON;

   lcd1602_refresh_ctrl #(
      .TICK_DIV  (D),
      .PWR_TICKS (P),
      .CLR_TICKS (C)
   ) dut (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .init_done  (init_done),
      .frame_done (frame_done),
      .LCD_DATA   (LCD_DATA),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_EN     (LCD_EN),
      .LCD_ON     (LCD_ON)
   );

   always #5 sys_clk = ~sys_clk;

   int         n = 0;          // clock edges since reset release
   int         run_id = 0;
   int         cur_j = -1;     // position in frame of the byte on the bus
   logic [7:0] mbuf [32];
   logic [7:0] exp_data = 8'h00;
   logic       exp_rs = 1'b0;
   int         vectors = 0;
   int         miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, req);
      end
   endtask

   function automatic bit is_start(input int t);
      int r;
      if (t < int'(P)) return 1'b0;
      r = t - int'(P);
      if (r < 12) return (r % 3 == 0);
      if (r < 12 + int'(C)) return 1'b0;
      return ((r - int'(C)) % 3 == 0);
   endfunction

   function automatic int xfer_idx(input int t);
      int r;
      r = t - int'(P);
      return (r < 12) ? r / 3 : (r - int'(C)) / 3;
   endfunction

   function automatic logic [7:0] cmd_of(input int k);
      case (k)
         0:       return 8'h38;
         1:       return 8'h0C;
         2:       return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // Timeline model: latch the byte at each transfer start, then apply host write
   always @(posedge sys_clk or posedge rst) begin
      int k;
      int j;
      if (rst) begin
         n = 0;
         for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
         exp_data = 8'h00;
         exp_rs   = 1'b0;
         cur_j    = -1;
      end else begin
         n++;
         if (n % int'(D) == 0 && is_start(n / int'(D))) begin
            k = xfer_idx(n / int'(D));
            if (k < 4) begin
               exp_rs   = 1'b0;
               exp_data = cmd_of(k);
               cur_j    = -1;
            end else begin
               j = (k - 4) % 34;
               cur_j = j;
               if (j == 0) begin
                  exp_rs = 1'b0; exp_data = 8'h80;
               end else if (j <= 16) begin
                  exp_rs = 1'b1; exp_data = mbuf[j - 1];
               end else if (j == 17) begin
                  exp_rs = 1'b0; exp_data = 8'hC0;
               end else begin
                  exp_rs = 1'b1; exp_data = mbuf[j - 2];
               end
            end
         end
         if (wr_en) mbuf[wr_addr] = wr_data;
      end
   end

   // Per-cycle compare plus literal pins on known edges
   always @(negedge sys_clk) begin
      int  q;
      bit  exp_en;
      bit  exp_fd;
      q      = n / int'(D);
      exp_en = (q >= 1) && is_start(q - 1);
      exp_fd = (n > 0) && (n % int'(D) == 0) && (q >= int'(F0 + FT)) &&
               ((q - int'(F0)) % int'(FT) == 0);
      check("lcd_en", LCD_EN, exp_en);
      check("lcd_rs", LCD_RS, exp_rs);
      check("lcd_data", LCD_DATA, exp_data);
      check("lcd_rw", LCD_RW, 0);
      check("lcd_on", LCD_ON, (n >= 1));
      check("init_done", init_done, (n >= int'(F0 * D)));
      check("frame_done", frame_done, exp_fd);
      if (run_id == 0) begin
         case (n)
            15:  check("lit_no_en_pwr", LCD_EN, 0);
            16:  begin check("lit_first_en", LCD_EN, 1); check("lit_first_cmd", LCD_DATA, 8'h38); end
            67:  check("lit_init_low", init_done, 0);
            68:  check("lit_init_high", init_done, 1);
            84:  begin check("lit_H", LCD_DATA, 8'h48); check("lit_H_rs", LCD_RS, 1); end
            144: check("lit_collide_old", LCD_DATA, 8'h20);
            300: check("lit_i", LCD_DATA, 8'h69);
            475: check("lit_fd_low", frame_done, 0);
            476: check("lit_fd_high", frame_done, 1);
            552: check("lit_collide_new", LCD_DATA, 8'h41);
            default: ;
         endcase
      end else begin
         case (n)
            16:  check("lit_rerun_cmd", LCD_DATA, 8'h38);
            84:  check("lit_rerun_clear", LCD_DATA, 8'h20);
            476: check("lit_rerun_fd", frame_done, 1);
            default: ;
         endcase
      end
   end

   task automatic wait_edge(input int target);
      while (n != target) @(negedge sys_clk);
   endtask

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge sys_clk);
      wr_en = 1'b0;
   endtask

   initial begin
      int guard;
      bit found;
      repeat (3) @(negedge sys_clk);
      rst = 1'b0;
      wait_edge(5);
      host_write(5'd0, 8'h48);
      host_write(5'd17, 8'h69);
      wait_edge(139);
      host_write(5'd5, 8'h41);
      wait_edge(900);
      while (n < 1400) begin
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_addr = 5'($urandom_range(0, 31));
         wr_data = 8'($urandom_range(32, 126));
         @(negedge sys_clk);
      end
      wr_en = 1'b0;

      found = 1'b0;
      guard = 0;
      while (!found && guard < 600) begin
         @(negedge sys_clk);
         guard++;
         found = (LCD_EN === 1'b1) && (cur_j >= 1) && (cur_j <= 16);
      end
      check("line1_en_seen", found, 1);
      #1 rst = 1'b1;
      #1;
      check("async_en_drop", LCD_EN, 0);
      check("async_init_clr", init_done, 0);
      check("async_on_off", LCD_ON, 0);
      run_id = 1;
      repeat (3) @(negedge sys_clk);
      rst = 1'b0;
      wait_edge(480);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
